// File: rtl/vec_pack_pkg.sv
// Shared types and constants for the 8-bit to 16-bit beat packer.
package vec_pack_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 16;

  localparam logic [1:0] BE_LO  = 2'b01;
  localparam logic [1:0] BE_HI  = 2'b10;
  localparam logic [1:0] BE_ALL = 2'b11;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

  // A lone byte sits in the first-filled lane; the other lane reads as zero.
  function automatic logic [OUT_W-1:0] place_partial(input logic [IN_W-1:0] b, input bit lsb_first);
    return lsb_first ? {8'h00, b} : {b, 8'h00};
  endfunction

  function automatic logic [1:0] partial_be(input bit lsb_first);
    return lsb_first ? BE_LO : BE_HI;
  endfunction

endpackage

// File: rtl/vec_pack_outreg.sv
// One-entry output word register with valid/ready; loads only when the slot is free.
module vec_pack_outreg
  import vec_pack_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [OUT_W-1:0] load_data,
  input  logic [1:0]       load_be,
  input  logic             load_last,
  input  logic             out_ready,
  output logic             slot_free,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_byte_en,
  output logic             out_last
);

  // Draining and refilling in the same cycle keeps the stream bubble-free.
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_byte_en <= 2'b00;
      out_last    <= 1'b0;
    end else if (load && slot_free) begin
      out_valid   <= 1'b1;
      out_data    <= load_data;
      out_byte_en <= load_be;
      out_last    <= load_last;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/vec_pack_ctrl.sv
// Pairs 8-bit producer beats into 16-bit consumer words, flushing partial
// words on in_last or after an idle timeout.
module vec_pack_ctrl
  import vec_pack_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_byte_en,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_t            state, state_nx;
  logic [IN_W-1:0]   hold, hold_nx;
  logic [CW-1:0]     idle, idle_nx;
  logic              sf, acc, timed_out;
  logic              load, load_last;
  logic [OUT_W-1:0]  load_data;
  logic [1:0]        load_be;

  assign in_ready  = sf;
  assign acc       = in_valid && sf;
  assign timed_out = (TIMEOUT != 0) && (idle == TMO);
  assign busy      = (state == HALF) || out_valid;

  // Next-state, hold byte, idle counter and output-register load request.
  always_comb begin
    state_nx  = state;
    hold_nx   = hold;
    idle_nx   = idle;
    load      = 1'b0;
    load_data = '0;
    load_be   = 2'b00;
    load_last = 1'b0;
    case (state)
      EMPTY: begin
        idle_nx = '0;
        if (acc && in_last) begin
          load      = 1'b1;
          load_data = place_partial(in_data, LSB_FIRST);
          load_be   = partial_be(LSB_FIRST);
          load_last = 1'b1;
        end else if (acc) begin
          hold_nx  = in_data;
          state_nx = HALF;
        end else begin
          state_nx = EMPTY;
        end
      end
      HALF: begin
        if (acc) begin
          // A byte arriving on the expiry cycle completes the word.
          load      = 1'b1;
          load_data = LSB_FIRST ? {in_data, hold} : {hold, in_data};
          load_be   = BE_ALL;
          load_last = in_last;
          state_nx  = EMPTY;
          idle_nx   = '0;
        end else if (timed_out && sf) begin
          load      = 1'b1;
          load_data = place_partial(hold, LSB_FIRST);
          load_be   = partial_be(LSB_FIRST);
          load_last = 1'b0;
          state_nx  = EMPTY;
          idle_nx   = '0;
        end else if (timed_out) begin
          idle_nx = idle;
        end else begin
          idle_nx = idle + CW'(1);
        end
      end
      default: begin
        state_nx = EMPTY;
        idle_nx  = '0;
      end
    endcase
  end

  // Controller state, held first byte and idle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      hold  <= '0;
      idle  <= '0;
    end else begin
      state <= state_nx;
      hold  <= hold_nx;
      idle  <= idle_nx;
    end
  end

  vec_pack_outreg u_outreg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
    .load_be    (load_be),
    .load_last  (load_last),
    .out_ready  (out_ready),
    .slot_free  (sf),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_byte_en(out_byte_en),
    .out_last   (out_last)
  );

endmodule
